dtree_seq_walker: RTL and testbench



---
 rtl/dtree_pkg.sv | 44 ++++
 rtl/dtree_node_cmp.sv | 55 +++++
 rtl/dtree_seq_walker.sv | 137 +++++++++++++
 tb/tb_dtree_seq_walker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the sequential decision-tree walker:
// node word layout, FSM states and the root address.
package dtree_pkg;

    localparam int IDX_W     = 3;
    localparam int SHIFT_W   = 3;
    localparam int ROOT_ADDR = 0;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_e;

    function automatic int node_w(input int feat_w, input int addr_w);
        return 1 + IDX_W + SHIFT_W + feat_w + 2 * addr_w;
    endfunction

    // Field LSB offsets, MSB to LSB: is_node, feat_idx, shift, thr, left, right
    function automatic int right_lsb();
        return 0;
    endfunction

    function automatic int left_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int thr_lsb(input int addr_w);
        return 2 * addr_w;
    endfunction

    function automatic int shift_lsb(input int feat_w, input int addr_w);
        return 2 * addr_w + feat_w;
    endfunction

    function automatic int idx_lsb(input int feat_w, input int addr_w);
        return 2 * addr_w + feat_w + SHIFT_W;
    endfunction

    function automatic int is_node_bit(input int feat_w, input int addr_w);
        return 2 * addr_w + feat_w + SHIFT_W + IDX_W;
    endfunction

endpackage

// File: rtl/dtree_node_cmp.sv
// Combinational evaluation of one tree node: feature select, shift,
// threshold compare and branch choice, plus leaf / bad-index flags.
module dtree_node_cmp
    import dtree_pkg::*;
#(
    parameter int N_FEAT  = 5,
    parameter int FEAT_W  = 8,
    parameter int ADDR_W  = 7,
    parameter int CLASS_W = 1,
    localparam int NODE_W = node_w(FEAT_W, ADDR_W)
) (
    input  logic [NODE_W-1:0]        node,
    input  logic [N_FEAT*FEAT_W-1:0] feat,
    output logic                     is_leaf,
    output logic                     bad_idx,
    output logic [CLASS_W-1:0]       leaf_class,
    output logic [ADDR_W-1:0]        next_ptr
);

    localparam int ISN_BIT = is_node_bit(FEAT_W, ADDR_W);
    localparam int IDX_LSB = idx_lsb(FEAT_W, ADDR_W);
    localparam int SH_LSB  = shift_lsb(FEAT_W, ADDR_W);
    localparam int THR_LSB = thr_lsb(ADDR_W);
    localparam int L_LSB   = left_lsb(ADDR_W);
    localparam int R_LSB   = right_lsb();

    logic               is_node;
    logic [IDX_W-1:0]   idx;
    logic [SHIFT_W-1:0] sh;
    logic [FEAT_W-1:0]  thr;
    logic [FEAT_W-1:0]  sel;
    logic [FEAT_W-1:0]  shifted;
    logic               le;

    always_comb begin
        is_node = node[ISN_BIT];
        idx     = node[IDX_LSB +: IDX_W];
        sh      = node[SH_LSB +: SHIFT_W];
        thr     = node[THR_LSB +: FEAT_W];
        sel     = '0;
        // Out-of-range indices select zero; bad_idx aborts the walk anyway
        for (int i = 0; i < N_FEAT; i++) begin
            if (32'(idx) == i) begin
                sel = feat[i*FEAT_W +: FEAT_W];
            end
        end
        shifted    = sel >> sh;
        le         = shifted <= thr;
        next_ptr   = le ? node[L_LSB +: ADDR_W] : node[R_LSB +: ADDR_W];
        is_leaf    = !is_node;
        bad_idx    = is_node && (32'(idx) >= N_FEAT);
        leaf_class = thr[CLASS_W-1:0];
    end

endmodule

// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree classifier: walks a loadable node table one
// node per cycle through a single shared comparator.
module dtree_seq_walker
    import dtree_pkg::*;
#(
    parameter int N_FEAT    = 5,
    parameter int FEAT_W    = 8,
    parameter int ADDR_W    = 7,
    parameter int CLASS_W   = 1,
    parameter int MAX_STEPS = 32,
    localparam int NODE_W   = node_w(FEAT_W, ADDR_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [NODE_W-1:0]        cfg_wdata,
    output logic                     cfg_ready,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err,
    output logic                     busy
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         ptr_q, ptr_d;
    logic [STEP_W-1:0]         steps_q, steps_d;
    logic [N_FEAT*FEAT_W-1:0]  feat_q, feat_d;
    logic [CLASS_W-1:0]        cls_q, cls_d;
    logic                      err_q, err_d;
    logic [NODE_W-1:0]         table_q [DEPTH];

    logic                      is_leaf;
    logic                      bad_idx;
    logic [CLASS_W-1:0]        leaf_class;
    logic [ADDR_W-1:0]         next_ptr;
    logic                      table_we;

    assign table_we = cfg_we && (state_q == IDLE);

    dtree_node_cmp #(
        .N_FEAT  (N_FEAT),
        .FEAT_W  (FEAT_W),
        .ADDR_W  (ADDR_W),
        .CLASS_W (CLASS_W)
    ) u_cmp (
        .node       (table_q[ptr_q]),
        .feat       (feat_q),
        .is_leaf    (is_leaf),
        .bad_idx    (bad_idx),
        .leaf_class (leaf_class),
        .next_ptr   (next_ptr)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        steps_d = steps_q;
        feat_d  = feat_q;
        cls_d   = cls_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    feat_d  = in_feat;
                    ptr_d   = ADDR_W'(ROOT_ADDR);
                    steps_d = '0;
                    state_d = WALK;
                end
            end
            WALK: begin
                // A leaf wins even when the step budget is exhausted
                if (is_leaf) begin
                    cls_d   = leaf_class;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (bad_idx || steps_q == STEP_W'(MAX_STEPS)) begin
                    cls_d   = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ptr_d   = next_ptr;
                    steps_d = steps_q + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            steps_q <= '0;
            feat_q  <= '0;
            cls_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            steps_q <= steps_d;
            feat_q  <= feat_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (table_we) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_class = cls_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_dtree_seq_walker.sv
// Scoreboard bench for dtree_seq_walker: directed vectors push expected
// class/err/latency, a monitor compares on each output handshake.
module tb_dtree_seq_walker;

    localparam int NODE_W = 29;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [6:0]        cfg_addr = '0;
    logic [NODE_W-1:0] cfg_wdata = '0;
    logic              cfg_ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [39:0]       in_feat = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [0:0]        out_class;
    logic              out_err;
    logic              busy;

    typedef struct {
        int cls;
        int err;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   rise_seen = 0;
    int   rise_cyc = 0;

    dtree_seq_walker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [NODE_W-1:0] mk(input int n, input int fi,
        input int sh, input int thr, input int l, input int r);
        return {1'(n), 3'(fi), 3'(sh), 8'(thr), 7'(l), 7'(r)};
    endfunction

    function automatic logic [39:0] fv(input int f0, input int f4);
        return {8'(f4), 24'h0, 8'(f0)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            rise_seen = 0;
        end else begin
            if (out_valid && !rise_seen) begin
                rise_seen = 1;
                rise_cyc  = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("class", 32'(out_class), e.cls);
                    check("err", 32'(out_err), e.err);
                    check("latency", rise_cyc - e.acc, e.lat);
                end
                rise_seen = 0;
            end
        end
    end

    // All tasks start and end at #1 after a rising edge
    task automatic wr(input int a, input logic [NODE_W-1:0] w);
        cfg_we    = 1'b1;
        cfg_addr  = 7'(a);
        cfg_wdata = w;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("in_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [39:0] f, input int c, input int e,
        input int lat);
        wait_ready();
        in_valid = 1'b1;
        in_feat  = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back('{c, e, lat, cyc});
    endtask

    task automatic send_wr(input logic [39:0] f, input int a,
        input logic [NODE_W-1:0] w, input int c, input int lat);
        wait_ready();
        in_valid  = 1'b1;
        in_feat   = f;
        cfg_we    = 1'b1;
        cfg_addr  = 7'(a);
        cfg_wdata = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        sb.push_back('{c, 0, lat, cyc});
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_class", 32'(out_class), 0);
        check("rst_out_err", 32'(out_err), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty table: root is an all-zero leaf of class 0
        send(fv(8'h15, 0), 0, 0, 1);
        drain();

        // Depth-2 tree on feature 0, threshold 10 after >>1
        wr(0, mk(1, 0, 1, 10, 1, 2));
        wr(1, mk(0, 0, 0, 1, 0, 0));
        wr(2, mk(0, 0, 0, 0, 0, 0));
        send(fv(20, 0), 1, 0, 2);
        send(fv(22, 0), 0, 0, 2);
        send(fv(21, 0), 1, 0, 2);
        drain();

        // Feature 4 (highest index), shift 2, threshold 3
        wr(0, mk(1, 4, 2, 3, 1, 2));
        send(fv(0, 15), 1, 0, 2);
        send(fv(0, 16), 0, 0, 2);
        drain();

        // Bad feature indices
        wr(0, mk(1, 6, 0, 0, 1, 2));
        send(fv(0, 0), 0, 1, 1);
        wr(0, mk(1, 5, 0, 255, 1, 2));
        send(fv(0, 0), 0, 1, 1);
        drain();

        // Self-loop aborts after the step budget
        wr(0, mk(1, 0, 0, 255, 0, 0));
        send(fv(7, 0), 0, 1, 33);
        drain();

        // Write and accept in the same cycle: walk sees the new root
        send_wr(fv(0, 0), 0, mk(0, 0, 0, 1, 0, 0), 1, 1);
        drain();

        // Backpressure: result held, cfg writes ignored while in DONE
        out_ready = 1'b0;
        send(fv(0, 0), 1, 0, 1);
        begin
            int t = 0;
            while (!out_valid && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 7'd0;
            cfg_wdata = mk(0, 0, 0, 0, 0, 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_class", 32'(out_class), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_cfg_ready", 32'(cfg_ready), 0);
            @(posedge clk); #1;
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        drain();
        send(fv(0, 0), 1, 0, 1);
        drain();

        // Reset mid-walk discards the result and clears the table
        wr(0, mk(1, 0, 0, 255, 0, 0));
        wait_ready();
        in_valid = 1'b1;
        in_feat  = fv(1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(fv(1, 0), 0, 0, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
